sr04_ranger: RTL

//  Parametrised HC-SR04 ranging engine. Issues the trigger pulse, times the echo
//  in 1 us ticks and converts it to centimetres. Adds single-shot or auto-repeat

---
 rtl/sr04_ranger.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sr04_ranger.sv
// HC-SR04 ranging engine: trigger pulse, echo timing in 1 us ticks, cm conversion.
// Optional 4-sample running average of valid results when SR04_AVG4_EN is defined.
module sr04_ranger #(
    parameter int TRIG_US     = 10,
    parameter int WAIT_MAX_US = 25000,
    parameter int ECHO_MAX_US = 25000,
    parameter int COOL_US     = 60000,
    parameter int CNT_W       = 17,
    parameter int DIST_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick_1us,
    input  logic              i_start,
    input  logic              i_auto_en,
    input  logic              echo,
    output logic              o_trigger,
    output logic [DIST_W-1:0] o_distance,
    output logic              o_valid,
    output logic              o_timeout,
    output logic              o_busy
);
    localparam int PW = CNT_W + 11;

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_COOL} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              echo_m_q, echo_s_q;
    logic              trig_q, trig_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              meas_done;
    logic [PW-1:0]     prod, quot;
    logic [DIST_W-1:0] conv;

    // d = cnt*1131 >> 16 approximates cnt/58; saturate when it overflows DIST_W.
    always_comb begin
        prod = {11'd0, cnt_q} * PW'(1131);
        quot = prod >> 16;
        conv = (|(quot >> DIST_W)) ? '1 : quot[DIST_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        meas_done = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: if (i_start || i_auto_en) state_d = S_TRIG;
            S_TRIG: if (i_tick_1us && cnt_q == CNT_W'(TRIG_US - 1)) state_d = S_WAIT;
            S_WAIT: begin
                if (echo_s_q) begin
                    state_d = S_MEAS;
                end else if (i_tick_1us && cnt_q == CNT_W'(WAIT_MAX_US - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_COOL;
                end
            end
            S_MEAS: begin
                // A falling echo wins over a coincident tick, so cnt_q is the final count.
                if (!echo_s_q) begin
                    meas_done = 1'b1;
                    state_d   = S_COOL;
                end else if (i_tick_1us && cnt_q == CNT_W'(ECHO_MAX_US - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_COOL;
                end
            end
            S_COOL: if (i_tick_1us && cnt_q == CNT_W'(COOL_US - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
        else if (i_tick_1us)    cnt_d = cnt_q + 1'b1;
        else                    cnt_d = cnt_q;

        trig_d = (state_d == S_TRIG);
        busy_d = (state_d != S_IDLE);
    end

`ifdef SR04_AVG4_EN
    logic [DIST_W-1:0] hist_q [4];
    logic [DIST_W-1:0] hist_d [4];
    logic              filled_q, filled_d;
    logic              upd_q, upd_d;
    logic [DIST_W+1:0] sum;

    always_comb begin
        hist_d   = hist_q;
        filled_d = filled_q;
        upd_d    = meas_done;
        if (meas_done) begin
            // The first result after reset seeds the whole history.
            if (!filled_q) begin
                hist_d = '{conv, conv, conv, conv};
            end else begin
                hist_d[3] = hist_q[2];
                hist_d[2] = hist_q[1];
                hist_d[1] = hist_q[0];
                hist_d[0] = conv;
            end
            filled_d = 1'b1;
        end
        sum     = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
        dist_d  = upd_q ? sum[DIST_W+1:2] : dist_q;
        valid_d = upd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q   <= '{default: '0};
            filled_q <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            filled_q <= filled_d;
            upd_q    <= upd_d;
        end
    end
`else
    always_comb begin
        dist_d  = meas_done ? conv : dist_q;
        valid_d = meas_done;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_m_q  <= 1'b0;
            echo_s_q  <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            trig_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            dist_q    <= '0;
        end else begin
            echo_m_q  <= echo;
            echo_s_q  <= echo_m_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            dist_q    <= dist_d;
        end
    end

    assign o_trigger  = trig_q;
    assign o_busy     = busy_q;
    assign o_valid    = valid_q;
    assign o_timeout  = timeout_q;
    assign o_distance = dist_q;
endmodule
